// File: rtl/wb_deserializer_pkg.sv
// Shared constants for the serial-link receiver: register map, frame geometry,
// STATUS bit positions and receiver FSM states.
package WBDeserializer;
  localparam logic [1:0] ADR_DATA   = 2'd0;
  localparam logic [1:0] ADR_STATUS = 2'd1;
  localparam logic [1:0] ADR_CTRL   = 2'd2;
  localparam int NUM_REGS   = 3;
  localparam int FRAME_BITS = 27;
  localparam int WORD_BITS  = 9;

  localparam int ST_VALID   = 0;
  localparam int ST_K_LO    = 1;
  localparam int ST_K_HI    = 3;
  localparam int ST_OVERRUN = 4;
  localparam int ST_FERR    = 5;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
endpackage

// File: rtl/wb_deserializer_receiver.sv
// Synchronizes the serial line, finds start edges and mid-bit samples a 27-bit frame.
// frame_valid_o / ferr_o are single-cycle pulses in the stop-bit sample cycle.
module serial_receiver
  import WBDeserializer::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  input  logic                  data_i,
  input  logic                  enable_i,
  output logic [FRAME_BITS-1:0] frame_o,
  output logic                  frame_valid_o,
  output logic                  ferr_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [4:0]    LAST_BIT  = 5'(FRAME_BITS - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_rx_d;
  rx_state_t              r_state, w_state_nxt;
  logic [CW-1:0]          r_cnt, w_cnt_nxt;
  logic [4:0]             r_bit, w_bit_nxt;
  logic [FRAME_BITS-1:0]  r_shift, w_shift_nxt;
  logic                   w_rx, w_rise;

  assign w_rx    = r_sync[SYNC_STAGES-1];
  assign w_rise  = w_rx & ~r_rx_d;
  assign frame_o = r_shift;

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_sync  <= '0;
      r_rx_d  <= 1'b0;
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], data_i};
      r_rx_d  <= w_rx;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt + 1'b1;
    w_bit_nxt     = r_bit;
    w_shift_nxt   = r_shift;
    frame_valid_o = 1'b0;
    ferr_o        = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        w_bit_nxt = '0;
        if (w_rise && enable_i) w_state_nxt = START;
      end
      START: begin
        // Half a bit in: confirms the start bit and aligns later samples to bit centres.
        if (r_cnt == HALF_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = w_rx ? DATA : IDLE;
        end
      end
      DATA: begin
        if (r_cnt == FULL_LAST) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {r_shift[FRAME_BITS-2:0], w_rx};
          if (r_bit == LAST_BIT) w_state_nxt = STOP;
          else                   w_bit_nxt   = r_bit + 1'b1;
        end
      end
      STOP: begin
        if (r_cnt == FULL_LAST) begin
          w_cnt_nxt     = '0;
          w_state_nxt   = IDLE;
          frame_valid_o = ~w_rx;
          ferr_o        = w_rx;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end
endmodule

// File: rtl/wb_deserializer.sv
// Wishbone register front end for the serial-link receiver: DATA, STATUS, CTRL.
// Zero-wait-state slave; address 3 answers with ERR_O.
module wb_deserializer
  import WBDeserializer::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        data_i,
  output logic        rx_valid_o,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic [31:0] ADR_I,
  input  logic [31:0] DAT_I,
  output logic        ACK_O,
  output logic        ERR_O,
  output logic [31:0] DAT_O
);
  logic [FRAME_BITS-1:0] w_frame;
  logic                  w_frame_vld, w_ferr;
  logic [23:0]           r_data;
  logic [2:0]            r_k;
  logic                  r_valid, r_ovr, r_ferr, r_en;
  logic [1:0]            w_adr;
  logic                  w_req, w_mapped, w_rd_data, w_wr_ctrl, w_clr_err;
  logic [WORD_BITS-1:0]  w_w2, w_w1, w_w0;
  logic [31:0]           w_status;
  logic                  w_unused;

  serial_receiver #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rx (
    .CLK_I        (CLK_I),
    .RST_I        (RST_I),
    .data_i       (data_i),
    .enable_i     (r_en),
    .frame_o      (w_frame),
    .frame_valid_o(w_frame_vld),
    .ferr_o       (w_ferr)
  );

  assign w_w2 = w_frame[3*WORD_BITS-1 -: WORD_BITS];
  assign w_w1 = w_frame[2*WORD_BITS-1 -: WORD_BITS];
  assign w_w0 = w_frame[WORD_BITS-1:0];

  assign w_adr     = ADR_I[1:0];
  assign w_req     = CYC_I & STB_I;
  assign w_mapped  = int'(w_adr) < NUM_REGS;
  assign ACK_O     = w_req & w_mapped;
  assign ERR_O     = w_req & ~w_mapped;
  assign w_rd_data = ACK_O & ~WE_I & (w_adr == ADR_DATA);
  assign w_wr_ctrl = ACK_O & WE_I & (w_adr == ADR_CTRL);
  assign w_clr_err = w_wr_ctrl & DAT_I[1];
  assign w_unused  = ^{ADR_I[31:2], DAT_I[31:2]};

  always_comb begin
    w_status                   = '0;
    w_status[ST_VALID]         = r_valid;
    w_status[ST_K_HI:ST_K_LO]  = r_k;
    w_status[ST_OVERRUN]       = r_ovr;
    w_status[ST_FERR]          = r_ferr;
  end

  always_comb begin
    DAT_O = '0;
    if (ACK_O && !WE_I) begin
      case (w_adr)
        ADR_DATA:   DAT_O = {8'b0, r_data};
        ADR_STATUS: DAT_O = w_status;
        ADR_CTRL:   DAT_O = {31'b0, r_en};
        default:    DAT_O = '0;
      endcase
    end
  end

  // A commit outranks a same-cycle DATA read, and a new error outranks its clear.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_data  <= '0;
      r_k     <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
      r_ferr  <= 1'b0;
      r_en    <= 1'b1;
    end else begin
      if (w_frame_vld) begin
        r_data  <= {w_w2[7:0], w_w1[7:0], w_w0[7:0]};
        r_k     <= {w_w2[8], w_w1[8], w_w0[8]};
        r_valid <= 1'b1;
      end else if (w_rd_data) begin
        r_valid <= 1'b0;
      end
      if (w_frame_vld && r_valid && !w_rd_data) r_ovr <= 1'b1;
      else if (w_clr_err)                       r_ovr <= 1'b0;
      if (w_ferr)         r_ferr <= 1'b1;
      else if (w_clr_err) r_ferr <= 1'b0;
      if (w_wr_ctrl) r_en <= DAT_I[0];
    end
  end

  assign rx_valid_o = r_valid;
endmodule

// File: tb/tb_wb_deserializer.sv
// Directed bench for wb_deserializer: frame-level register model plus literal pins.
module tb_wb_deserializer;
  import WBDeserializer::*;

  logic        CLK_I = 1'b0;
  logic        RST_I, data_i, CYC_I, STB_I, WE_I;
  logic [31:0] ADR_I, DAT_I;
  logic        rx_valid_o, ACK_O, ERR_O;
  logic [31:0] DAT_O;

  always #5 CLK_I = ~CLK_I;

  wb_deserializer #(.CLKS_PER_BIT(8), .SYNC_STAGES(2)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .data_i(data_i), .rx_valid_o(rx_valid_o),
    .CYC_I(CYC_I), .STB_I(STB_I), .WE_I(WE_I), .ADR_I(ADR_I), .DAT_I(DAT_I),
    .ACK_O(ACK_O), .ERR_O(ERR_O), .DAT_O(DAT_O)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Register-level model of what the Wishbone master should observe.
  logic [23:0] m_data;
  logic [2:0]  m_k;
  logic        m_valid, m_ovr, m_ferr, m_en;
  logic        m_check = 1'b0;
  logic [31:0] rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_data = '0; m_k = '0; m_valid = 0; m_ovr = 0; m_ferr = 0; m_en = 1;
  endtask

  function automatic logic [31:0] model_reg(input logic [1:0] adr);
    case (adr)
      2'd0:    return {8'b0, m_data};
      2'd1:    return {26'b0, m_ferr, m_ovr, m_k, m_valid};
      2'd2:    return {31'b0, m_en};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_frame(input logic en, input logic [8:0] w2, w1, w0, input logic stop);
    if (en) begin
      if (stop == 1'b0) begin
        if (m_valid) m_ovr = 1'b1;
        m_valid = 1'b1;
        m_data  = {w2[7:0], w1[7:0], w0[7:0]};
        m_k     = {w2[8], w1[8], w0[8]};
      end else begin
        m_ferr = 1'b1;
      end
    end
  endtask

  always @(negedge CLK_I) begin
    if (m_check) begin
      chk("rx_valid_o", {31'b0, rx_valid_o}, {31'b0, m_valid});
      if (!CYC_I) chk("idle bus outputs", {29'b0, ACK_O, ERR_O, |DAT_O}, 32'h0);
    end
  end

  task automatic wb_read(input logic [1:0] adr, input string name, output logic [31:0] rdat);
    CYC_I = 1; STB_I = 1; WE_I = 0; ADR_I = 32'hABCD_0000 | {30'b0, adr};
    @(negedge CLK_I);
    chk({name, " ack/err"}, {30'b0, ACK_O, ERR_O}, (adr == 2'd3) ? 32'h1 : 32'h2);
    chk({name, " data"}, DAT_O, model_reg(adr));
    rdat = DAT_O;
    @(posedge CLK_I); #1;
    CYC_I = 0; STB_I = 0; ADR_I = '0;
    if (adr == ADR_DATA) m_valid = 1'b0;
  endtask

  task automatic wb_write(input logic [1:0] adr, input logic [31:0] dat, input string name);
    CYC_I = 1; STB_I = 1; WE_I = 1; ADR_I = {30'b0, adr}; DAT_I = dat;
    @(negedge CLK_I);
    chk({name, " ack/err/dat"}, {29'b0, ACK_O, ERR_O, |DAT_O},
        (adr == 2'd3) ? 32'h2 : 32'h4);
    @(posedge CLK_I); #1;
    CYC_I = 0; STB_I = 0; WE_I = 0; ADR_I = '0; DAT_I = '0;
    if (adr == ADR_CTRL) begin
      m_en = dat[0];
      if (dat[1]) begin m_ovr = 0; m_ferr = 0; end
    end
  endtask

  // mode 1: DATA read in the commit cycle; 2: CTRL error-clear in the stop-sample
  // cycle; 3: CTRL write 0 in the middle of the frame.
  task automatic send_frame(input logic [8:0] w2, w1, w0, input logic stop,
                            input int mode, input int hold_hi);
    logic [28:0] bits;
    logic        en0;
    bits    = {1'b1, w2, w1, w0, stop};
    en0     = m_en;
    m_check = 1'b0;
    for (int i = 28; i >= 0; i--) begin
      data_i = bits[i];
      if (i == 0 && (mode == 1 || mode == 2)) begin
        repeat (6) @(posedge CLK_I); #1;
        if (mode == 1) wb_read(ADR_DATA, "collide DATA read", rd);
        else           wb_write(ADR_CTRL, 32'h3, "collide CTRL clear");
        @(posedge CLK_I); #1;
      end else if (i == 18 && mode == 3) begin
        repeat (3) @(posedge CLK_I); #1;
        wb_write(ADR_CTRL, 32'h0, "mid-frame disable");
        repeat (4) @(posedge CLK_I); #1;
      end else begin
        repeat (8) @(posedge CLK_I); #1;
      end
    end
    if (hold_hi > 0) begin
      data_i = 1'b1;
      repeat (hold_hi) @(posedge CLK_I); #1;
    end
    data_i = 1'b0;
    repeat (6) @(posedge CLK_I); #1;
    model_frame(en0, w2, w1, w0, stop);
    m_check = 1'b1;
  endtask

  initial begin
    RST_I = 1; data_i = 0; CYC_I = 0; STB_I = 0; WE_I = 0; ADR_I = '0; DAT_I = '0;
    model_reset();
    repeat (3) @(posedge CLK_I); #1;
    RST_I = 0;
    m_check = 1'b1;
    repeat (2) @(posedge CLK_I); #1;

    wb_read(ADR_STATUS, "reset STATUS", rd);
    wb_read(ADR_DATA, "reset DATA", rd);
    wb_read(ADR_CTRL, "reset CTRL", rd);
    chk("reset CTRL literal", rd, 32'h1);
    wb_read(2'd3, "unmapped read", rd);
    wb_write(2'd3, 32'hFFFF_FFFF, "unmapped write");
    wb_write(ADR_DATA, 32'h1234_5678, "DATA write ignored");
    wb_read(ADR_DATA, "DATA after write", rd);

    send_frame(9'h1BC, 9'h012, 9'h034, 1'b0, 0, 0);
    wb_read(ADR_STATUS, "basic STATUS", rd);
    chk("basic STATUS literal", rd, 32'h0000_0009);
    wb_read(ADR_DATA, "basic DATA", rd);
    chk("basic DATA literal", rd, 32'h00BC_1234);
    wb_read(ADR_STATUS, "basic STATUS after read", rd);
    chk("basic STATUS after read literal", rd, 32'h0000_0008);

    send_frame(9'h100, 9'h001, 9'h002, 1'b0, 0, 0);
    send_frame(9'h0AA, 9'h0BB, 9'h0CC, 1'b0, 0, 0);
    wb_read(ADR_STATUS, "overrun STATUS", rd);
    chk("overrun bit set literal", {31'b0, rd[4]}, 32'h1);
    wb_read(ADR_DATA, "overrun DATA", rd);
    chk("overrun DATA literal", rd, 32'h00AA_BBCC);
    wb_write(ADR_CTRL, 32'h2, "CTRL clear errors");
    wb_read(ADR_STATUS, "overrun cleared STATUS", rd);
    chk("overrun bit clear literal", {31'b0, rd[4]}, 32'h0);
    wb_write(ADR_CTRL, 32'h1, "CTRL re-enable");

    send_frame(9'h1FF, 9'h1FF, 9'h1FF, 1'b1, 0, 40);
    wb_read(ADR_STATUS, "ferr STATUS", rd);
    chk("ferr STATUS literal", rd, 32'h0000_0020);
    wb_read(ADR_DATA, "ferr DATA", rd);
    chk("ferr DATA unchanged literal", rd, 32'h00AA_BBCC);
    send_frame(9'h155, 9'h0F0, 9'h00F, 1'b0, 0, 0);
    wb_read(ADR_STATUS, "post-ferr STATUS", rd);
    chk("post-ferr STATUS literal", rd, 32'h0000_0029);
    wb_read(ADR_DATA, "post-ferr DATA", rd);
    chk("post-ferr DATA literal", rd, 32'h0055_F00F);

    send_frame(9'h000, 9'h000, 9'h000, 1'b1, 2, 0);
    wb_read(ADR_STATUS, "clear vs new ferr STATUS", rd);
    chk("clear vs new ferr literal", rd, 32'h0000_0028);
    wb_write(ADR_CTRL, 32'h3, "CTRL clear keep enable");
    wb_read(ADR_STATUS, "cleared STATUS", rd);

    m_check = 1'b0;
    data_i = 1'b1;
    repeat (2) @(posedge CLK_I); #1;
    data_i = 1'b0;
    m_check = 1'b1;
    repeat (30) @(posedge CLK_I); #1;
    wb_read(ADR_STATUS, "glitch STATUS", rd);
    chk("glitch STATUS literal", rd, 32'h0000_0008);

    send_frame(9'h011, 9'h022, 9'h033, 1'b0, 0, 0);
    send_frame(9'h144, 9'h055, 9'h166, 1'b0, 1, 0);
    wb_read(ADR_STATUS, "collision STATUS", rd);
    chk("collision STATUS literal", rd, 32'h0000_000B);
    wb_read(ADR_DATA, "collision DATA", rd);
    chk("collision DATA literal", rd, 32'h0044_5566);

    send_frame(9'h077, 9'h088, 9'h099, 1'b0, 3, 0);
    wb_read(ADR_CTRL, "disabled CTRL", rd);
    chk("disabled CTRL literal", rd, 32'h0);
    wb_read(ADR_DATA, "mid-frame disable DATA", rd);
    chk("mid-frame disable DATA literal", rd, 32'h0077_8899);
    send_frame(9'h1AA, 9'h1BB, 9'h1CC, 1'b0, 0, 0);
    wb_read(ADR_STATUS, "disabled STATUS", rd);
    chk("disabled STATUS literal", rd, 32'h0);
    wb_read(ADR_DATA, "disabled DATA", rd);

    wb_write(ADR_CTRL, 32'h1, "CTRL enable before reset");
    send_frame(9'h123, 9'h045, 9'h067, 1'b0, 0, 0);
    m_check = 1'b0;
    data_i = 1'b1;
    repeat (8) @(posedge CLK_I); #1;
    data_i = 1'b0;
    repeat (16) @(posedge CLK_I); #1;
    wb_write(ADR_CTRL, 32'h0, "CTRL disable before reset");
    RST_I = 1'b1;
    @(posedge CLK_I); #1;
    RST_I = 1'b0;
    model_reset();
    m_check = 1'b1;
    repeat (4) @(posedge CLK_I); #1;
    wb_read(ADR_STATUS, "mid-frame reset STATUS", rd);
    chk("mid-frame reset STATUS literal", rd, 32'h0);
    wb_read(ADR_CTRL, "mid-frame reset CTRL", rd);
    chk("mid-frame reset CTRL literal", rd, 32'h1);
    wb_read(ADR_DATA, "mid-frame reset DATA", rd);
    send_frame(9'h0DE, 9'h1AD, 9'h0BE, 1'b0, 0, 0);
    wb_read(ADR_STATUS, "after reset STATUS", rd);
    chk("after reset STATUS literal", rd, 32'h0000_0005);
    wb_read(ADR_DATA, "after reset DATA", rd);
    chk("after reset DATA literal", rd, 32'h00DE_ADBE);

    repeat (4) @(posedge CLK_I); #1;
    m_check = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
